// File: rtl/valu_pkg.sv
// Shared definitions for the vector add/sub result stages: sew codes, opSel bit
// positions and the 10-bit-per-lane layout of the packed adder sum.
package valu_pkg;

    localparam int DATA_W      = 64;
    localparam int LANES       = 8;
    localparam int LANE_STRIDE = 10;
    localparam int PACK_W      = LANES * LANE_STRIDE + 1;

    // Field offsets inside one lane: bit 0 is the guard, 1..8 the sum byte, 9 the extension.
    localparam int LANE_SUM_LSB = 1;
    localparam int LANE_MSB_BIT = 8;
    localparam int LANE_X_BIT   = 9;

    localparam int OP_SUB    = 1;
    localparam int OP_SIGNED = 2;
    localparam int OP_SAT    = 4;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_e;

    // Index of the most significant lane of element e; the 3-bit wrap makes sew=3 land on lane 7.
    function automatic logic [2:0] top_lane(input logic [2:0] e, input logic [1:0] sew);
        return (e << sew) | ((3'd1 << sew) - 3'd1);
    endfunction

endpackage

// File: rtl/vadd_result_pack_if.sv
// Beat-level handshake bundle between the adder result stage and its neighbours.
// slave is the stage's view, master the producer/consumer side.
interface vadd_result_pack_if #(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int SEW_WIDTH      = 2,
    parameter int OPSEL_WIDTH    = 6,
    parameter int TAG_WIDTH      = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [REQ_DATA_WIDTH+16:0]  in_result;
    logic [SEW_WIDTH-1:0]        in_sew;
    logic [OPSEL_WIDTH-1:0]      in_opSel;
    logic [TAG_WIDTH-1:0]        in_tag;
    logic                        out_valid;
    logic                        out_ready;
    logic [REQ_DATA_WIDTH-1:0]   out_data;
    logic [7:0]                  out_cmask;
    logic                        out_vxsat;
    logic [TAG_WIDTH-1:0]        out_tag;
    logic                        vxsat_sticky;
    logic                        vxsat_clr;

    modport slave (
        input  in_valid, in_result, in_sew, in_opSel, in_tag, out_ready, vxsat_clr,
        output in_ready, out_valid, out_data, out_cmask, out_vxsat, out_tag, vxsat_sticky
    );

    modport master (
        output in_valid, in_result, in_sew, in_opSel, in_tag, out_ready, vxsat_clr,
        input  in_ready, out_valid, out_data, out_cmask, out_vxsat, out_tag, vxsat_sticky
    );
endinterface

// File: rtl/vadd_sat_lane.sv
// Combinational extract/saturate of all elements of one packed sum for the given sew.
// Latency: none (pure logic). Backpressure: n/a, owned by the enclosing stage.
module vadd_sat_lane
    import valu_pkg::*;
(
    input  logic [PACK_W-1:0] res_i,
    input  sew_e              sew_i,
    input  logic              is_sub_i,
    input  logic              sat_i,
    input  logic              sgn_i,
    output logic [DATA_W-1:0] data_o,
    output logic [LANES-1:0]  cmask_o,
    output logic              vxsat_o
);
    logic [DATA_W-1:0] sum;
    logic [LANES-1:0]  x_lane;
    logic [LANES-1:0]  m_lane;
    logic [LANES-1:0]  ovf_elem;
    logic [2:0]        byte_elem [LANES];
    logic [2:0]        byte_top  [LANES];
    logic              unused_guard;

    // Guard bits and bit 80 carry no information for this stage.
    assign unused_guard = ^res_i;

    always_comb begin
        sum    = '0;
        x_lane = '0;
        m_lane = '0;
        for (int k = 0; k < LANES; k++) begin
            sum[8*k +: 8] = res_i[LANE_STRIDE*k + LANE_SUM_LSB +: 8];
            x_lane[k]     = res_i[LANE_STRIDE*k + LANE_X_BIT];
            m_lane[k]     = res_i[LANE_STRIDE*k + LANE_MSB_BIT];
        end
    end

    always_comb begin
        cmask_o  = '0;
        ovf_elem = '0;
        for (int e = 0; e < LANES; e++) begin
            if (e < (LANES >> sew_i)) begin
                if (!sat_i) begin
                    cmask_o[e] = is_sub_i ? x_lane[top_lane(3'(e), sew_i)]
                                          : ~x_lane[top_lane(3'(e), sew_i)];
                end else if (!sgn_i) begin
                    ovf_elem[e] = is_sub_i ? ~x_lane[top_lane(3'(e), sew_i)]
                                           : x_lane[top_lane(3'(e), sew_i)];
                end else begin
                    ovf_elem[e] = x_lane[top_lane(3'(e), sew_i)] ^ m_lane[top_lane(3'(e), sew_i)];
                end
            end
        end
    end

    // Clamp values are built byte by byte: the extension bit tells which rail was crossed.
    always_comb begin
        data_o = sum;
        for (int b = 0; b < LANES; b++) begin
            byte_elem[b] = 3'(b) >> sew_i;
            byte_top[b]  = top_lane(byte_elem[b], sew_i);
            if (ovf_elem[byte_elem[b]]) begin
                if (!sgn_i) begin
                    data_o[8*b +: 8] = {8{x_lane[byte_top[b]]}};
                end else if (3'(b) == byte_top[b]) begin
                    data_o[8*b +: 8] = {x_lane[byte_top[b]], {7{~x_lane[byte_top[b]]}}};
                end else begin
                    data_o[8*b +: 8] = {8{~x_lane[byte_top[b]]}};
                end
            end
        end
    end

    assign vxsat_o = |ovf_elem;

endmodule

// File: rtl/vadd_result_pack.sv
// Strips guard bits from the packed add/sub sum, saturates, and emits per-element carry masks.
// Latency 1 cycle; 1 beat/cycle. A 1-entry skid absorbs a stall; in_ready is registered.
module vadd_result_pack
    import valu_pkg::*;
#(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int SEW_WIDTH      = 2,
    parameter int OPSEL_WIDTH    = 6,
    parameter int TAG_WIDTH      = 8
) (
    input logic               clk,
    input logic               rst,
    vadd_result_pack_if.slave bus
);
    typedef struct packed {
        logic [REQ_DATA_WIDTH-1:0] data;
        logic [7:0]                cmask;
        logic                      vxsat;
        logic [TAG_WIDTH-1:0]      tag;
    } beat_t;

    logic [SEW_WIDTH-1:0]      sew;
    logic [OPSEL_WIDTH-1:0]    op_sel;
    logic [REQ_DATA_WIDTH-1:0] calc_data;
    logic [7:0]                calc_cmask;
    logic                      calc_vxsat;
    beat_t                     new_beat;
    beat_t                     out_q, out_d, skid_q, skid_d;
    logic                      out_vld_q, out_vld_d;
    logic                      skid_vld_q, skid_vld_d;
    logic                      in_rdy_q, in_rdy_d;
    logic                      sticky_q, sticky_d;
    logic                      accept;
    logic                      out_fire;

    assign sew    = bus.in_sew;
    assign op_sel = bus.in_opSel;

    vadd_sat_lane u_sat (
        .res_i    (bus.in_result),
        .sew_i    (sew_e'(sew)),
        .is_sub_i (op_sel[OP_SUB]),
        .sat_i    (op_sel[OP_SAT]),
        .sgn_i    (op_sel[OP_SIGNED]),
        .data_o   (calc_data),
        .cmask_o  (calc_cmask),
        .vxsat_o  (calc_vxsat)
    );

    always_comb begin
        accept     = bus.in_valid & in_rdy_q;
        out_fire   = out_vld_q & bus.out_ready;
        new_beat   = '{data: calc_data, cmask: calc_cmask, vxsat: calc_vxsat, tag: bus.in_tag};
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || bus.out_ready) begin
            // Output slot frees this cycle: the skid (older) drains before any new beat.
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = accept;
                if (accept) begin
                    skid_d = new_beat;
                end
            end else if (accept) begin
                out_d     = new_beat;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = new_beat;
            skid_vld_d = 1'b1;
        end
        in_rdy_d = ~skid_vld_d;
        sticky_d = (sticky_q & ~bus.vxsat_clr) | (out_fire & out_q.vxsat);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= in_rdy_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.in_ready     = in_rdy_q;
    assign bus.out_valid    = out_vld_q;
    assign bus.out_data     = out_q.data;
    assign bus.out_cmask    = out_q.cmask;
    assign bus.out_vxsat    = out_q.vxsat;
    assign bus.out_tag      = out_q.tag;
    assign bus.vxsat_sticky = sticky_q;

endmodule

// File: tb/tb_vadd_result_pack.sv
// Scoreboard bench for vadd_result_pack: directed plan vectors plus randomized traffic
// with random backpressure, checked against an element-level arithmetic model.
module tb_vadd_result_pack;

    typedef struct {
        bit [63:0] data;
        bit [7:0]  cmask;
        bit        vxsat;
        bit [7:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    bit   rand_done = 0;
    bit [7:0] tag_ctr = 8'd0;

    vadd_result_pack_if #(.REQ_DATA_WIDTH(64), .SEW_WIDTH(2), .OPSEL_WIDTH(6), .TAG_WIDTH(8)) bus ();

    vadd_result_pack #(.REQ_DATA_WIDTH(64), .SEW_WIDTH(2), .OPSEL_WIDTH(6), .TAG_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Element-level reference: rebuild each element's sum as an integer and apply the rules.
    function automatic exp_t model(input bit [80:0] res, input bit [1:0] sew, input bit [5:0] op,
                                   input bit [7:0] tag);
        exp_t      r;
        int        nb   = 1 << sew;
        int        w    = 8 * nb;
        int        n    = 8 / nb;
        bit [63:0] s    = '0;
        bit [63:0] mask;
        bit [63:0] elem;
        bit        x, m;
        int        t;
        for (int k = 0; k < 8; k++) s[8*k +: 8] = res[10*k+1 +: 8];
        mask    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        r.data  = '0;
        r.cmask = '0;
        r.vxsat = 1'b0;
        r.tag   = tag;
        for (int e = 0; e < n; e++) begin
            t    = e * nb + nb - 1;
            x    = res[10*t+9];
            m    = res[10*t+8];
            elem = (s >> (e * w)) & mask;
            if (!op[4]) begin
                r.cmask[e] = op[1] ? x : !x;
            end else if (!op[2]) begin
                if (!op[1] && x) begin
                    elem = mask; r.vxsat = 1'b1;
                end else if (op[1] && !x) begin
                    elem = '0; r.vxsat = 1'b1;
                end
            end else if (x != m) begin
                elem    = x ? ((mask >> 1) + 64'd1) : (mask >> 1);
                r.vxsat = 1'b1;
            end
            r.data = r.data | (elem << (e * w));
        end
        return r;
    endfunction

    function automatic bit [80:0] pack(input bit [63:0] s, input bit [7:0] x);
        bit [80:0] r;
        r = 81'({$urandom, $urandom, $urandom});
        for (int k = 0; k < 8; k++) begin
            r[10*k+1 +: 8] = s[8*k +: 8];
            r[10*k+9]      = x[k];
        end
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bit [80:0] res, input bit [1:0] sew, input bit [5:0] op, input exp_t e);
        bit rdy;
        bit acc = 0;
        bus.in_valid  = 1'b1;
        bus.in_result = res;
        bus.in_sew    = sew;
        bus.in_opSel  = op;
        bus.in_tag    = e.tag;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) acc = 1;
        end
        if (acc) exp_q.push_back(e);
        else begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: tag %h never accepted, in_ready=%b", e.tag, bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit [7:0] tag);
        bit [80:0] res = 81'({$urandom, $urandom, $urandom});
        bit [1:0]  sew = 2'($urandom_range(0, 3));
        bit [5:0]  op  = 6'($urandom);
        send(res, sew, op, model(res, sew, op, tag));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat: tag %h data %h, expected none", bus.out_tag, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_tag",   64'(bus.out_tag),   64'(e.tag));
                    chk("out_data",  bus.out_data,       e.data);
                    chk("out_cmask", 64'(bus.out_cmask), 64'(e.cmask));
                    chk("out_vxsat", 64'(bus.out_vxsat), 64'(e.vxsat));
                end
            end
        end
    end

    initial begin
        exp_t t2;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_sew    = '0;
        bus.in_opSel  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        bus.vxsat_clr = 1'b0;
        #2 rst_n = 1'b0;
        cycles(3);
        chk("rst_out_valid", 64'(bus.out_valid),    64'd0);
        chk("rst_out_data",  bus.out_data,          64'd0);
        chk("rst_out_cmask", 64'(bus.out_cmask),    64'd0);
        chk("rst_out_vxsat", 64'(bus.out_vxsat),    64'd0);
        chk("rst_out_tag",   64'(bus.out_tag),      64'd0);
        chk("rst_sticky",    64'(bus.vxsat_sticky), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),     64'd0);
        rst_n = 1'b1;
        cycles(1);
        chk("in_ready_after_release", 64'(bus.in_ready), 64'd1);

        // Directed plan vectors with literal expectations.
        bus.out_ready = 1'b1;
        send(pack(64'h1111_1111_1111_1100, 8'hFE), 2'd0, 6'h00,
             '{data: 64'h1111_1111_1111_1100, cmask: 8'h01, vxsat: 1'b0, tag: 8'hA1});
        @(negedge clk);
        chk("latency_1cyc", 64'(bus.out_valid), 64'd1);
        cycles(1);
        t2 = '{data: 64'h1234_5678_FFFF_FFFF, cmask: 8'h00, vxsat: 1'b1, tag: 8'hA2};
        send(pack(64'h1234_5678_0000_0005, 8'h08), 2'd2, 6'h10, t2);
        cycles(2);
        chk("sticky_set", 64'(bus.vxsat_sticky), 64'd1);
        bus.vxsat_clr = 1'b1;
        cycles(1);
        bus.vxsat_clr = 1'b0;
        chk("sticky_clr", 64'(bus.vxsat_sticky), 64'd0);
        send(pack(64'hDEF0_9ABC_5678_1234, 8'h83), 2'd1, 6'h16,
             '{data: 64'hDEF0_7FFF_5678_8000, cmask: 8'h00, vxsat: 1'b1, tag: 8'hA3});
        send(pack(64'h0123_4567_89AB_CDEF, 8'h80), 2'd3, 6'h02,
             '{data: 64'h0123_4567_89AB_CDEF, cmask: 8'h01, vxsat: 1'b0, tag: 8'hA4});
        cycles(2);
        bus.vxsat_clr = 1'b1;
        cycles(1);
        bus.vxsat_clr = 1'b0;

        // Clear and set landing on the same edge: set must win.
        bus.out_ready = 1'b0;
        t2.tag = 8'hA5;
        send(pack(64'h1234_5678_0000_0005, 8'h08), 2'd2, 6'h10, t2);
        bus.out_ready = 1'b1;
        bus.vxsat_clr = 1'b1;
        cycles(1);
        bus.vxsat_clr = 1'b0;
        chk("sticky_set_wins", 64'(bus.vxsat_sticky), 64'd1);
        bus.vxsat_clr = 1'b1;
        cycles(1);
        bus.vxsat_clr = 1'b0;

        // Backpressure: two beats fill output + skid, then in_ready must drop.
        bus.out_ready = 1'b0;
        send_rand(8'd1);
        send_rand(8'd2);
        chk("bp_in_ready_low", 64'(bus.in_ready),  64'd0);
        chk("bp_out_valid",    64'(bus.out_valid), 64'd1);
        fork
            begin @(posedge clk); #1; bus.out_ready = 1'b1; end
            begin send_rand(8'd3); send_rand(8'd4); end
        join
        cycles(4);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset while holding a full skid: everything in flight is discarded.
        send(pack(64'h1234_5678_0000_0005, 8'h08), 2'd2, 6'h10, t2);
        cycles(2);
        bus.out_ready = 1'b0;
        send_rand(8'd5);
        send_rand(8'd6);
        chk("pre_rst_skid_full", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid),    64'd0);
        chk("midrst_in_ready",  64'(bus.in_ready),     64'd0);
        chk("midrst_sticky",    64'(bus.vxsat_sticky), 64'd0);
        cycles(2);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        cycles(1);
        chk("post_rst_in_ready",  64'(bus.in_ready),  64'd1);
        cycles(4);
        chk("post_rst_no_stale",  64'(bus.out_valid), 64'd0);

        // Randomized traffic with random downstream stalls.
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 9) < 7);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) cycles(1);
                    tag_ctr++;
                    send_rand(tag_ctr);
                end
                rand_done = 1;
            end
        join
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycles(1);
        chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vadd_result_pack.md
Name: vadd_result_pack

Overview:
- Downstream stage of the vector add/sub unit block; consumes its 81-bit guard-bit-packed sum.
- Strips guard/extension bits to produce the 64-bit element result.
- Applies saturation for saturating add/sub, and produces the per-element carry/borrow mask for carry-out ops.
- Registered, valid/ready pipeline stage with a skid buffer. Feeds the ALU result mux and writeback.

Parameters:
- REQ_DATA_WIDTH, 64, element datapath width; only 64 supported (8 byte lanes).
- SEW_WIDTH, 2, width of the sew code.
- OPSEL_WIDTH, 6, width of the opSel code.
- TAG_WIDTH, 8, opaque tag carried with each beat.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_result  in  REQ_DATA_WIDTH+17  packed adder sum
- in_sew  in  SEW_WIDTH  0=8b, 1=16b, 2=32b, 3=64b
- in_opSel  in  OPSEL_WIDTH  same code the adder received
- in_tag  in  TAG_WIDTH  passthrough
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts
- out_data  out  REQ_DATA_WIDTH  element results
- out_cmask  out  8  per-element carry/borrow, element e at bit e; bits at and above 8>>sew are 0
- out_vxsat  out  1  some element of this beat saturated
- out_tag  out  TAG_WIDTH  passthrough
- vxsat_sticky  out  1  accumulated saturation flag
- vxsat_clr  in  1  clears vxsat_sticky

Behaviour:
- Reset (rst=0, async): out_valid=0, out_data=0, out_cmask=0, out_vxsat=0, out_tag=0, vxsat_sticky=0, skid empty, in_ready=1 from the first cycle after release.
- Packed format, byte lane k=0..7:
  - sum byte = in_result[10k+8:10k+1]
  - x_k = in_result[10k+9]
  - in_result[10k] is the guard bit and is ignored
  - in_result[80] is ignored
- Element e spans lanes e*B..e*B+B-1, where B=1<<sew. Top lane t=e*B+B-1. Element msb m = in_result[10t+8].
- Mode decode:
  - is_sub=opSel[1]
  - sat=opSel[4]
  - signed=opSel[2]
- Non-saturating (sat=0): out_data = concatenated sum bytes. Carry-out c_e = ~x_t for add. Borrow = x_t for sub (is_sub=1). out_cmask[e] = c_e or borrow accordingly. out_vxsat=0.
- Saturating unsigned (sat=1, signed=0), mask cmask=0:
  - Add with x_t=1: element = all ones, flag.
  - Sub with x_t=0: element = 0, flag.
  - Otherwise pass the sum.
- Saturating signed (sat=1, signed=1), cmask=0:
  - Overflow when x_t != m.
  - If x_t=0, m=1: element = 0x7F..F.
  - If x_t=1, m=0: element = 0x80..0.
  - Flag on overflow.
- out_vxsat = OR of per-element flags.
- vxsat_sticky:
  - Set on any handshake (out_valid & out_ready) carrying out_vxsat=1.
  - vxsat_clr clears it.
  - Same-cycle clr and set: set wins.
- Pipeline:
  - Computation is combinational on input; the result is registered.
  - Latency is 1 cycle from input handshake to out_valid. Throughput is 1 beat/cycle.
- Handshake:
  - Input accepted on in_valid & in_ready.
  - out_valid is held, and out_data/out_cmask/out_vxsat/out_tag stay stable, until out_ready.
  - in_ready is registered: in_ready = ~skid_full.
- Skid buffer:
  - Output register full and out_ready=0 while a beat is accepted: the beat goes to the 1-entry skid, and in_ready drops the next cycle.
  - On the next out_ready, the skid moves to the output register, and in_ready rises the next cycle.
  - No beat is dropped, duplicated, or reordered.
- Reset mid-stream discards all held beats. No partial output.

Decomposition:
- Shared package (valu_pkg): SEW codes, opSel bit indices (OP_SUB=1, OP_SIGNED=2, OP_SAT=4), LANE_STRIDE=10, lane field offsets.
- One sub-module, vadd_sat_lane: combinational per-element extract/saturate for a given sew. Top level holds the decode, output register, skid and sticky flag.

Test Plan:
- SEW=8 add, lane0 sum 0x00 with x_0=0, other lanes sum 0x11 with x=1 -> out_data=0x1111111111111100, out_cmask=0x01, out_vxsat=0, one cycle after accept.
- SEW=32 unsigned sat add, element0 x_3=1, sum 0x00000005; element1 x_7=0, sum 0x12345678 -> out_data=0x12345678FFFFFFFF, out_vxsat=1, cmask=0; sticky set, then vxsat_clr clears it.
- SEW=16 signed sat sub, element0 x=1 m=0 -> element 0x8000; element2 x=0 m=1 -> 0x7FFF; elements 1 and 3 pass unchanged; out_vxsat=1.
- SEW=64 sub, x_7=1 -> out_cmask=0x01 (borrow); bits 7:1 are 0.
- Backpressure: 4 back-to-back beats with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted; all 4 beats emerge in order with tags 1..4; no duplicates.
- Assert rst low with the skid full -> out_valid=0 and in_ready=0 during reset; in_ready=1 the cycle after release; vxsat_sticky=0; no stale beat emitted.
